// File: rtl/branch_unit_pipe.sv
// RV32 branch resolution: condition compare, target and sequential-PC adders,
// a one- or two-slice valid/ready pipe, and saturating retire counters.
module branch_unit_pipe #(
    parameter int XLEN   = 32,
    parameter int PC_W   = 32,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  op_a,
    input  logic [XLEN-1:0]  op_b,
    input  logic [2:0]       funct3,
    input  logic [PC_W-1:0]  pc,
    input  logic [PC_W-1:0]  imm,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic [PC_W-1:0]  target,
    output logic [PC_W-1:0]  next_pc,
    output logic             mispredict,
    output logic             illegal,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] cnt_branches,
    output logic [CNT_W-1:0] cnt_mispredict
);
    logic            cond_taken;
    logic            cond_illegal;
    logic [PC_W-1:0] sum_target;
    logic [PC_W-1:0] sum_seq;

    // Illegal encodings resolve not-taken, so mispredict falls out as pred_taken.
    always_comb begin
        cond_taken   = 1'b0;
        cond_illegal = (funct3[2:1] == 2'b01);
        case (funct3)
            3'b000:  cond_taken = (op_a == op_b);
            3'b001:  cond_taken = (op_a != op_b);
            3'b100:  cond_taken = ($signed(op_a) < $signed(op_b));
            3'b101:  cond_taken = ($signed(op_a) >= $signed(op_b));
            3'b110:  cond_taken = (op_a < op_b);
            3'b111:  cond_taken = (op_a >= op_b);
            default: cond_taken = 1'b0;
        endcase
    end

    assign sum_target = pc + imm;
    assign sum_seq    = pc + PC_W'(4);

    generate
        if (STAGES == 1) begin : g_one
            logic            v_q, v_d, tk_q, tk_d, mp_q, mp_d, il_q, il_d;
            logic [PC_W-1:0] tg_q, tg_d, np_q, np_d;

            assign in_ready = !v_q || out_ready;

            always_comb begin
                v_d  = v_q;
                tk_d = tk_q;
                mp_d = mp_q;
                il_d = il_q;
                tg_d = tg_q;
                np_d = np_q;
                if (in_ready) begin
                    v_d = in_valid;
                    if (in_valid) begin
                        tk_d = cond_taken;
                        il_d = cond_illegal;
                        tg_d = sum_target;
                        np_d = cond_taken ? sum_target : sum_seq;
                        mp_d = cond_taken ^ pred_taken;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q  <= 1'b0;
                    tk_q <= 1'b0;
                    mp_q <= 1'b0;
                    il_q <= 1'b0;
                    tg_q <= '0;
                    np_q <= '0;
                end else begin
                    v_q  <= v_d;
                    tk_q <= tk_d;
                    mp_q <= mp_d;
                    il_q <= il_d;
                    tg_q <= tg_d;
                    np_q <= np_d;
                end
            end

            assign out_valid  = v_q;
            assign taken      = tk_q;
            assign target     = tg_q;
            assign next_pc    = np_q;
            assign mispredict = mp_q;
            assign illegal    = il_q;
        end else begin : g_two
            logic            av_q, av_d, atk_q, atk_d, ail_q, ail_d, apr_q, apr_d;
            logic [PC_W-1:0] atg_q, atg_d, asq_q, asq_d;
            logic            bv_q, bv_d, btk_q, btk_d, bil_q, bil_d, bmp_q, bmp_d;
            logic [PC_W-1:0] btg_q, btg_d, bnp_q, bnp_d;
            logic            ready_b;

            assign ready_b  = !bv_q || out_ready;
            assign in_ready = !av_q || ready_b;

            // Slice 1 holds the compare result; slice 2 resolves the PC mux.
            always_comb begin
                av_d  = av_q;
                atk_d = atk_q;
                ail_d = ail_q;
                apr_d = apr_q;
                atg_d = atg_q;
                asq_d = asq_q;
                bv_d  = bv_q;
                btk_d = btk_q;
                bil_d = bil_q;
                bmp_d = bmp_q;
                btg_d = btg_q;
                bnp_d = bnp_q;
                if (in_ready) begin
                    av_d = in_valid;
                    if (in_valid) begin
                        atk_d = cond_taken;
                        ail_d = cond_illegal;
                        apr_d = pred_taken;
                        atg_d = sum_target;
                        asq_d = sum_seq;
                    end
                end
                if (ready_b) begin
                    bv_d = av_q;
                    if (av_q) begin
                        btk_d = atk_q;
                        bil_d = ail_q;
                        btg_d = atg_q;
                        bnp_d = atk_q ? atg_q : asq_q;
                        bmp_d = atk_q ^ apr_q;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    av_q  <= 1'b0;
                    atk_q <= 1'b0;
                    ail_q <= 1'b0;
                    apr_q <= 1'b0;
                    atg_q <= '0;
                    asq_q <= '0;
                    bv_q  <= 1'b0;
                    btk_q <= 1'b0;
                    bil_q <= 1'b0;
                    bmp_q <= 1'b0;
                    btg_q <= '0;
                    bnp_q <= '0;
                end else begin
                    av_q  <= av_d;
                    atk_q <= atk_d;
                    ail_q <= ail_d;
                    apr_q <= apr_d;
                    atg_q <= atg_d;
                    asq_q <= asq_d;
                    bv_q  <= bv_d;
                    btk_q <= btk_d;
                    bil_q <= bil_d;
                    bmp_q <= bmp_d;
                    btg_q <= btg_d;
                    bnp_q <= bnp_d;
                end
            end

            assign out_valid  = bv_q;
            assign taken      = btk_q;
            assign target     = btg_q;
            assign next_pc    = bnp_q;
            assign mispredict = bmp_q;
            assign illegal    = bil_q;
        end
    endgenerate

    logic             retire;
    logic [CNT_W-1:0] cb_q, cb_d, cm_q, cm_d;

    assign retire = out_valid && out_ready;

    // Clear wins over a same-cycle retire; counts stick at all-ones.
    always_comb begin
        cb_d = cb_q;
        cm_d = cm_q;
        if (clr_cnt) begin
            cb_d = '0;
            cm_d = '0;
        end else if (retire && !illegal) begin
            if (cb_q != '1) cb_d = cb_q + CNT_W'(1);
            if (mispredict && (cm_q != '1)) cm_d = cm_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cb_q <= '0;
            cm_q <= '0;
        end else begin
            cb_q <= cb_d;
            cm_q <= cm_d;
        end
    end

    assign cnt_branches   = cb_q;
    assign cnt_mispredict = cm_q;
endmodule
